alu_ctrl: RTL and testbench

Sequencing controller that sits on the operand/result side of the 16-bit ripple ALU (op[1:0], i0, i1 -> o, cout). It holds an internal register file, accepts three-address commands over a valid/ready handshake, drives registered operands and op to the ALU, samples the result and carry, and writes them back. It is the issuing end of the ALU interface; the ALU itself is instantiated outside this block.

---
 rtl/alu_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// alu_ctrl: register file plus command sequencer that drives the external
// 16-bit ripple ALU. One three-address command is processed every four cycles:
// accept, read operands, let the ALU settle, write back.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a command; direct loads accepted when no command
// READ  | operands and opcode registered onto the ALU inputs
// EXEC  | ALU inputs stable; result and carry captured
// WB    | result written to regs[rd], res/carry updated, done pulses
module alu_ctrl #(
    parameter int W    = 16,
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_data,
    output logic [1:0]    alu_op,
    output logic [W-1:0]  alu_i0,
    output logic [W-1:0]  alu_i1,
    input  logic [W-1:0]  alu_o,
    input  logic          alu_cout,
    output logic          done,
    output logic [W-1:0]  res,
    output logic          carry,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] EXEC = 2'd2;
    localparam logic [1:0] WB   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [1:0]    op_q;
    logic [AW-1:0] rd_q, rs1_q, rs2_q;
    logic [1:0]    alu_op_q;
    logic [W-1:0]  alu_i0_q, alu_i1_q;
    logic [W-1:0]  res_next_q;
    logic          cout_next_q;
    logic [W-1:0]  res_q;
    logic          carry_q;
    logic [W-1:0]  regs_q [NREG];

    logic accept;
    logic load;

    // A command handshake in IDLE takes priority over a coincident direct load.
    assign accept = (state_q == IDLE) && cmd_valid;
    assign load   = (state_q == IDLE) && ld_en && !cmd_valid;

    // Fixed four-state sequence; only IDLE waits on an input.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, command latch, ALU operand registers, result capture and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            alu_op_q    <= '0;
            alu_i0_q    <= '0;
            alu_i1_q    <= '0;
            res_next_q  <= '0;
            cout_next_q <= 1'b0;
            res_q       <= '0;
            carry_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= cmd_op;
                rd_q  <= cmd_rd;
                rs1_q <= cmd_rs1;
                rs2_q <= cmd_rs2;
            end
            if (state_q == READ) begin
                alu_op_q <= op_q;
                alu_i0_q <= regs_q[rs1_q];
                alu_i1_q <= regs_q[rs2_q];
            end
            if (state_q == EXEC) begin
                res_next_q  <= alu_o;
                cout_next_q <= alu_cout;
            end
            if (state_q == WB) begin
                res_q <= res_next_q;
                // Logic ops leave the carry flag untouched.
                if (!op_q[1]) carry_q <= cout_next_q;
            end
        end
    end

    // Register file: writeback in WB, direct loads only in IDLE (never both).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (state_q == WB) begin
            regs_q[rd_q] <= res_next_q;
        end else if (load) begin
            regs_q[ld_addr] <= ld_data;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign done      = (state_q == WB);
    assign alu_op    = alu_op_q;
    assign alu_i0    = alu_i0_q;
    assign alu_i1    = alu_i1_q;
    assign res       = res_q;
    assign carry     = carry_q;
    assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: a behavioural ALU closes the loop, and a reference model
// of the register file, result and carry flag predicts every observed value.
module tb_alu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [1:0]  alu_op;
    logic [15:0] alu_i0, alu_i1;
    logic [15:0] alu_o;
    logic        alu_cout;
    logic        done;
    logic [15:0] res;
    logic        carry;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_regs [8];
    logic [15:0] m_res;
    logic        m_carry;

    always #5 clk = ~clk;

    alu_ctrl #(.W(16), .NREG(8), .AW(3)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_op(alu_op), .alu_i0(alu_i0), .alu_i1(alu_i1),
        .alu_o(alu_o), .alu_cout(alu_cout),
        .done(done), .res(res), .carry(carry),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural ALU; logic ops drive a data-dependent carry-out the DUT must ignore.
    always_comb begin
        logic [16:0] s;
        s = 17'd0;
        case (alu_op)
            2'b00:   s = {1'b0, alu_i0} + {1'b0, alu_i1};
            2'b01:   s = {1'b0, alu_i0} + {1'b0, ~alu_i1} + 17'd1;
            2'b10:   s = {~alu_i0[0], alu_i0 & alu_i1};
            default: s = {~alu_i0[0], alu_i0 | alu_i1};
        endcase
        alu_o    = s[15:0];
        alu_cout = s[16];
    end

    // Expected result and post-command carry, from the arithmetic meaning of each op.
    function automatic void ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic c_in, output logic [15:0] r, output logic c_out);
        int unsigned sum;
        case (op)
            2'b00: begin sum = int'(a) + int'(b); r = 16'(sum); c_out = (sum > 65535); end
            2'b01: begin r = a - b; c_out = (a >= b); end
            2'b10: begin r = a & b; c_out = c_in; end
            default: begin r = a | b; c_out = c_in; end
        endcase
    endfunction

    task automatic load(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        @(negedge clk);
        ld_en = 1'b0; ld_addr = 3'($urandom); ld_data = 16'($urandom);
        m_regs[addr] = data;
    endtask

    // Issue one command from IDLE and check latency, ALU drive, result, flag and writeback.
    task automatic do_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic collide, input string tag);
        logic [15:0] a, b, er;
        logic        ec;
        int          lat;
        a = m_regs[rs1]; b = m_regs[rs2];
        ref_op(op, a, b, m_carry, er, ec);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        if (collide) begin ld_en = 1'b1; ld_addr = rs1; ld_data = ~a; end
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_idle: got %b want 1", tag, cmd_ready); end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; ld_en = 1'b0;
        cmd_op = 2'($urandom); cmd_rd = 3'($urandom); cmd_rs1 = 3'($urandom); cmd_rs2 = 3'($urandom);
        n_checks++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL %s ready_busy: got %b want 0", tag, cmd_ready); end
        lat = 1;
        while (done !== 1'b1 && lat < 8) begin @(negedge clk); lat++; end
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL %s done_latency: got %0d want 3", tag, lat); end
        n_checks++;
        if ({alu_op, alu_i0, alu_i1} !== {op, a, b})
            begin n_fail++; $display("FAIL %s alu_drive: got %h/%h/%h want %h/%h/%h", tag, alu_op, alu_i0, alu_i1, op, a, b); end
        m_regs[rd] = er; m_res = er; m_carry = ec;
        @(negedge clk);
        dbg_addr = rd; #1;
        n_checks++;
        if ({done, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL %s post_wb_ctrl: got done=%b ready=%b want 0/1", tag, done, cmd_ready); end
        n_checks++;
        if (res !== er) begin n_fail++; $display("FAIL %s res: got %h want %h", tag, res, er); end
        n_checks++;
        if (carry !== ec) begin n_fail++; $display("FAIL %s carry: got %b want %b", tag, carry, ec); end
        n_checks++;
        if (dbg_data !== er) begin n_fail++; $display("FAIL %s reg_rd: got %h want %h", tag, dbg_data, er); end
        if (collide && rd != rs1) begin
            dbg_addr = rs1; #1;
            n_checks++;
            if (dbg_data !== a) begin n_fail++; $display("FAIL %s dropped_load: got %h want %h", tag, dbg_data, a); end
        end
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            n_checks++;
            if (dbg_data !== m_regs[i]) begin n_fail++; $display("FAIL %s reg%0d: got %h want %h", tag, i, dbg_data, m_regs[i]); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b01; cmd_rd = 3'd2; cmd_rs1 = 3'd1; cmd_rs2 = 3'd3;
        ld_en = 1'b1; ld_addr = 3'd4; ld_data = 16'hA5A5; dbg_addr = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0; cmd_valid = 1'b0; ld_en = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_res = 16'h0; m_carry = 1'b0;
        n_checks++;
        if ({cmd_ready, done} !== 2'b10) begin n_fail++; $display("FAIL reset ctrl: got ready=%b done=%b want 1/0", cmd_ready, done); end
        n_checks++;
        if ({res, carry} !== 17'h0) begin n_fail++; $display("FAIL reset flags: got res=%h carry=%b want 0/0", res, carry); end
        n_checks++;
        if ({alu_op, alu_i0, alu_i1} !== 34'h0) begin n_fail++; $display("FAIL reset alu: got %h/%h/%h want 0", alu_op, alu_i0, alu_i1); end
        check_all_regs("reset");
    endtask

    task automatic test_directed();
        load(3'd1, 16'h0005);
        load(3'd2, 16'h0003);
        do_cmd(2'b00, 3'd3, 3'd1, 3'd2, 1'b0, "add_5_3");
        do_cmd(2'b01, 3'd4, 3'd1, 3'd2, 1'b0, "sub_5_3");
        do_cmd(2'b01, 3'd5, 3'd2, 3'd1, 1'b0, "sub_3_5");
        load(3'd6, 16'hFFFF);
        load(3'd7, 16'h0001);
        do_cmd(2'b00, 3'd6, 3'd6, 3'd7, 1'b0, "add_wrap");
        do_cmd(2'b10, 3'd0, 3'd1, 3'd2, 1'b0, "and_hold_carry");
        do_cmd(2'b11, 3'd0, 3'd0, 3'd3, 1'b0, "or_r0");
        check_all_regs("directed");
    endtask

    task automatic test_back_to_back();
        logic [15:0] ra, rb, junk;
        logic        ca, cb;
        load(3'd1, 16'h1234);
        load(3'd2, 16'h0FFF);
        ref_op(2'b00, m_regs[1], m_regs[2], m_carry, ra, ca);
        m_regs[3] = ra;
        ref_op(2'b01, m_regs[3], m_regs[1], ca, rb, cb);
        m_regs[4] = rb;
        junk = ~m_regs[5];
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rd = 3'd3; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b ready_first: got %b want 1", cmd_ready); end
        @(negedge clk);
        cmd_op = 2'b01; cmd_rd = 3'd4; cmd_rs1 = 3'd3; cmd_rs2 = 3'd1;
        n_checks++;
        if ({cmd_ready, done} !== 2'b00) begin n_fail++; $display("FAIL b2b read: got ready=%b done=%b want 0/0", cmd_ready, done); end
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 3'd5; ld_data = junk;
        n_checks++;
        if ({cmd_ready, done} !== 2'b00) begin n_fail++; $display("FAIL b2b exec: got ready=%b done=%b want 0/0", cmd_ready, done); end
        @(negedge clk);
        ld_en = 1'b0;
        n_checks++;
        if ({cmd_ready, done} !== 2'b01) begin n_fail++; $display("FAIL b2b wb1: got ready=%b done=%b want 0/1", cmd_ready, done); end
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, done, res, carry} !== {2'b10, ra, ca})
            begin n_fail++; $display("FAIL b2b idle1: got ready=%b done=%b res=%h c=%b want 1/0/%h/%b", cmd_ready, done, res, carry, ra, ca); end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b second_accept: got ready=%b want 0", cmd_ready); end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL b2b exec2: got done=%b want 0", done); end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b wb2: got done=%b want 1", done); end
        @(negedge clk);
        n_checks++;
        if ({done, res, carry} !== {1'b0, rb, cb}) begin n_fail++; $display("FAIL b2b result2: got done=%b res=%h c=%b want 0/%h/%b", done, res, carry, rb, cb); end
        m_res = rb; m_carry = cb;
        check_all_regs("b2b");
    endtask

    task automatic test_reset_inflight();
        load(3'd1, 16'h00F0);
        load(3'd2, 16'h000F);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rd = 3'd1; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_res = 16'h0; m_carry = 1'b0;
        n_checks++;
        if ({cmd_ready, done, carry, res} !== {3'b100, 16'h0}) begin n_fail++; $display("FAIL rst_inflight ctrl: got ready=%b done=%b c=%b res=%h want 1/0/0/0", cmd_ready, done, carry, res); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL rst_inflight no_done: got %b want 0", done); end
        end
        check_all_regs("rst_inflight");
    endtask

    task automatic test_ld_collide();
        load(3'd1, 16'h0100);
        load(3'd2, 16'h0023);
        do_cmd(2'b00, 3'd3, 3'd1, 3'd2, 1'b1, "collide_add");
        do_cmd(2'b11, 3'd7, 3'd2, 3'd1, 1'b1, "collide_or");
        check_all_regs("collide");
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0)
                load(3'($urandom), ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
            else
                do_cmd(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom_range(0, 4) == 0), "random");
        end
        check_all_regs("random");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_inflight();
        test_ld_collide();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
